sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3: ACCESS-phase length in clocks, legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 22: SRAM word-address width.
REQ-003 SHALL have port master_clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port master_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bootstrap_initdone_i, input, 1 bit: the boot image is fully loaded; the CPU side is enabled.
REQ-006 SHALL have port boot_req_i, input, 1 bit: bootstrap write request, held until boot_ack_o.
REQ-007 SHALL have ports boot_addr_i (input, ADDR_W bits) and boot_wdata_i (input, 16 bits): bootstrap write address and data.
REQ-008 SHALL have port boot_ack_o, output, 1 bit: one-cycle completion pulse to the bootstrap.
REQ-009 SHALL have ports cpu_req_i (input, 1 bit) and cpu_we_i (input, 1 bit): CPU request, held until cpu_ack_o; 1 = write.
REQ-010 SHALL have ports cpu_addr_i (input, ADDR_W bits), cpu_wdata_i (input, 16 bits) and cpu_be_i (input, 2 bits): CPU address, write data and byte enables.
REQ-011 SHALL have ports cpu_ack_o (output, 1 bit) and cpu_rdata_o (output, 16 bits): one-cycle completion pulse, and read data valid while cpu_ack_o is high.
REQ-012 SHALL have SRAM ports: sram_address_o (output, ADDR_W bits), sram_datain_o (output, 16 bits), sram_dataout_i (input, 16 bits), sram_cs_o, sram_oe_o, sram_we_o, sram_adv_o (outputs, 1 bit each, active-low), sram_lb_ub_o (output, 2 bits, active-low byte lanes {ub,lb}).
REQ-013 SHALL have port error_o, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 SHALL use an FSM with states IDLE, SETUP, ACCESS and HOLD; each transaction is IDLE->SETUP (1 clk)->ACCESS (WAIT_CYCLES clks)->HOLD (1 clk)->IDLE.
REQ-015 SHALL grant in IDLE as follows: while bootstrap_initdone_i=0, only boot_req_i is grantable; while it is 1, only cpu_req_i is grantable.
REQ-016 SHALL leave a CPU request made while initdone=0 pending, with no error and no ack.
REQ-017 SHALL set error_o and ignore the request when boot_req_i is high in IDLE while initdone=1.
REQ-018 SHALL latch the grant owner, address, data, we and be at the IDLE->SETUP edge; input changes during a transaction SHALL have no effect.
REQ-019 SHALL, in SETUP: sram_cs_o=0, address valid, oe=we=1.
REQ-020 SHALL, in ACCESS: for a write, we=0 and sram_datain_o is driven; for a read, oe=0.
REQ-021 SHALL, in HOLD: we=oe=1, cs=0, address held.
REQ-022 SHALL capture sram_dataout_i into cpu_rdata_o on the last ACCESS edge of a read; cpu_rdata_o SHALL hold until the next read.
REQ-023 SHALL assert the owner's ack for exactly the HOLD cycle, giving an ack at clock 2+WAIT_CYCLES after the request is sampled (5 for the default).
REQ-024 SHALL enable both lanes for bootstrap writes (sram_lb_ub_o=2'b00); for CPU accesses sram_lb_ub_o=~cpu_be_i; be=2'b00 on a CPU access SHALL set error_o and still complete.
REQ-025 SHALL hold sram_adv_o=0 at all times (asynchronous mode).
REQ-026 SHALL drive cs=oe=we=1 and lb_ub=2'b11 in IDLE.
REQ-027 SHALL allow back-to-back requests: a request held high through HOLD is re-granted in the following IDLE cycle, so the minimum turnaround is 1 IDLE clk.
REQ-028 SHALL let an initdone change mid-transaction take effect only at the next IDLE grant.
REQ-029 SHALL implement the ACCESS counter as 4 bits, loaded with WAIT_CYCLES-1 and decremented to 0.

Reset
REQ-030 SHALL, while master_rst_n_i=0, immediately force: state=IDLE; cs/oe/we=1; lb_ub=2'b11; adv=0; address, datain and cpu_rdata_o=0; both acks=0; error_o=0.
REQ-031 SHALL, on reset mid-transaction, abort it with no ack; the requester SHALL retry after reset.

Structure
REQ-032 SHALL place the FSM state encoding, the SRAM control idle constants and the WAIT_CYCLES legal range in the shared bootstrap package.
REQ-033 SHALL split out sub-module sram_access_timer (load/decrement/zero flag), used for the ACCESS count.

Verification
REQ-034 SHALL cover: boot write addr 0x000010 data 0xA5A5 with initdone=0 -> we low for 3 clks, lb_ub=00, boot_ack at clk 5.
REQ-035 SHALL cover: CPU read addr 0x3FFFFF with sram_dataout_i=0x1234, initdone=1 -> oe low for 3 clks, cpu_ack at clk 5, cpu_rdata_o=0x1234.
REQ-036 SHALL cover: CPU request while initdone=0, then initdone raised 10 clks later -> no SRAM activity before the rise, ack 5 clks after the grant.
REQ-037 SHALL cover: boot_req with initdone=1 -> error_o=1 sticky, SRAM stays idle, no boot_ack.
REQ-038 SHALL cover: CPU write be=2'b10 data 0xBEEF -> lb_ub=01, then a back-to-back read whose cs pulses are separated by 1 IDLE clk.
REQ-039 SHALL cover: master_rst_n_i low during ACCESS -> cs/we=1 in the same cycle, no ack, correct transaction after release.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter slice:
// FSM encoding, SRAM idle levels and access-length limits.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_HOLD
   } state_t;

   typedef enum logic {
      OWN_BOOT,
      OWN_CPU
   } owner_t;

   localparam logic       CTRL_IDLE  = 1'b1;
   localparam logic [1:0] LANES_IDLE = 2'b11;
   localparam logic [1:0] LANES_ALL  = 2'b00;

   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;

   // Timer starts one below the length because it counts down to zero
   function automatic logic [3:0] timer_load(int unsigned w);
      return 4'(w - 1);
   endfunction

endpackage

// File: rtl/sram_arbiter_timer.sv
// ACCESS-phase down counter: load, decrement, zero flag.
// The zero flag marks the last clock of the phase.
module sram_access_timer
   import sram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] load_val,
   output logic       zero
);

   logic [3:0] cnt;

   // Load takes priority so a new phase always restarts cleanly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-master asynchronous SRAM arbiter: bootstrap writes until
// init is done, then the CPU owns the memory.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int ADDR_W      = 22
) (
   input  logic              master_clk_i,
   input  logic              master_rst_n_i,
   input  logic              bootstrap_initdone_i,
   input  logic              boot_req_i,
   input  logic [ADDR_W-1:0] boot_addr_i,
   input  logic [15:0]       boot_wdata_i,
   output logic              boot_ack_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [15:0]       cpu_wdata_i,
   input  logic [1:0]        cpu_be_i,
   output logic              cpu_ack_o,
   output logic [15:0]       cpu_rdata_o,
   output logic [ADDR_W-1:0] sram_address_o,
   output logic [15:0]       sram_datain_o,
   input  logic [15:0]       sram_dataout_i,
   output logic              sram_cs_o,
   output logic              sram_oe_o,
   output logic              sram_we_o,
   output logic              sram_adv_o,
   output logic [1:0]        sram_lb_ub_o,
   output logic              error_o
);

   if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("sram_arbiter: WAIT_CYCLES out of range");
   end

   state_t state;
   owner_t owner;
   logic   wr_q;
   logic   t_zero;

   sram_access_timer u_timer (
      .clk      (master_clk_i),
      .rst_n    (master_rst_n_i),
      .load     (state == ST_SETUP),
      .dec      ((state == ST_ACCESS) && !t_zero),
      .load_val (timer_load(WAIT_CYCLES)),
      .zero     (t_zero)
   );

   // Asynchronous SRAM runs without address-valid strobes
   assign sram_adv_o = 1'b0;

   // Grant, sequence the SRAM strobes and issue the completion pulse
   always_ff @(posedge master_clk_i or negedge master_rst_n_i) begin
      if (!master_rst_n_i) begin
         state          <= ST_IDLE;
         owner          <= OWN_BOOT;
         wr_q           <= 1'b0;
         sram_cs_o      <= CTRL_IDLE;
         sram_oe_o      <= CTRL_IDLE;
         sram_we_o      <= CTRL_IDLE;
         sram_lb_ub_o   <= LANES_IDLE;
         sram_address_o <= '0;
         sram_datain_o  <= '0;
         cpu_rdata_o    <= '0;
         boot_ack_o     <= 1'b0;
         cpu_ack_o      <= 1'b0;
         error_o        <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bootstrap_initdone_i && boot_req_i) begin
                  error_o <= 1'b1;
               end
               if (!bootstrap_initdone_i && boot_req_i) begin
                  state          <= ST_SETUP;
                  owner          <= OWN_BOOT;
                  wr_q           <= 1'b1;
                  sram_address_o <= boot_addr_i;
                  sram_datain_o  <= boot_wdata_i;
                  sram_lb_ub_o   <= LANES_ALL;
                  sram_cs_o      <= 1'b0;
               end else if (bootstrap_initdone_i && cpu_req_i) begin
                  state          <= ST_SETUP;
                  owner          <= OWN_CPU;
                  wr_q           <= cpu_we_i;
                  sram_address_o <= cpu_addr_i;
                  sram_datain_o  <= cpu_wdata_i;
                  sram_lb_ub_o   <= ~cpu_be_i;
                  sram_cs_o      <= 1'b0;
                  if (cpu_be_i == 2'b00) begin
                     error_o <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               state <= ST_ACCESS;
               if (wr_q) begin
                  sram_we_o <= 1'b0;
               end else begin
                  sram_oe_o <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (t_zero) begin
                  state     <= ST_HOLD;
                  sram_we_o <= CTRL_IDLE;
                  sram_oe_o <= CTRL_IDLE;
                  if (!wr_q) begin
                     cpu_rdata_o <= sram_dataout_i;
                  end
                  if (owner == OWN_BOOT) begin
                     boot_ack_o <= 1'b1;
                  end else begin
                     cpu_ack_o <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               state        <= ST_IDLE;
               sram_cs_o    <= CTRL_IDLE;
               sram_lb_ub_o <= LANES_IDLE;
               boot_ack_o   <= 1'b0;
               cpu_ack_o    <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus
// randomized traffic against a phase-count reference model.
module tb_sram_arbiter;

   localparam int W  = 3;
   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          initdone = 1'b0;
   logic          boot_req = 1'b0;
   logic [AW-1:0] boot_addr = '0;
   logic [15:0]   boot_wdata = '0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [15:0]   cpu_wdata = '0;
   logic [1:0]    cpu_be = 2'b11;
   logic [15:0]   dout = '0;

   logic          boot_ack, cpu_ack, error;
   logic [15:0]   cpu_rdata, sram_datain;
   logic [AW-1:0] sram_address;
   logic          cs, oe, we, adv;
   logic [1:0]    lb_ub;

   sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
      .master_clk_i         (clk),
      .master_rst_n_i       (rst_n),
      .bootstrap_initdone_i (initdone),
      .boot_req_i           (boot_req),
      .boot_addr_i          (boot_addr),
      .boot_wdata_i         (boot_wdata),
      .boot_ack_o           (boot_ack),
      .cpu_req_i            (cpu_req),
      .cpu_we_i             (cpu_we),
      .cpu_addr_i           (cpu_addr),
      .cpu_wdata_i          (cpu_wdata),
      .cpu_be_i             (cpu_be),
      .cpu_ack_o            (cpu_ack),
      .cpu_rdata_o          (cpu_rdata),
      .sram_address_o       (sram_address),
      .sram_datain_o        (sram_datain),
      .sram_dataout_i       (dout),
      .sram_cs_o            (cs),
      .sram_oe_o            (oe),
      .sram_we_o            (we),
      .sram_adv_o           (adv),
      .sram_lb_ub_o         (lb_ub),
      .error_o              (error)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Reference: m_ph counts clocks since the grant
   // (1 = setup, 2..W+1 = access, W+2 = hold, 0 = idle)
   int            m_ph = 0;
   logic          m_boot = 1'b0;
   logic          m_wr = 1'b0;
   logic          m_err = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [15:0]   m_dat = '0;
   logic [15:0]   m_rdata = '0;
   logic [1:0]    m_lanes = 2'b11;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_err <= 1'b0; m_rdata <= '0;
         m_boot <= 1'b0; m_wr <= 1'b0; m_lanes <= 2'b11;
      end else if (m_ph == 0) begin
         if (initdone && boot_req) m_err <= 1'b1;
         if (!initdone && boot_req) begin
            m_ph <= 1; m_boot <= 1'b1; m_wr <= 1'b1;
            m_addr <= boot_addr; m_dat <= boot_wdata;
            m_lanes <= 2'b00;
         end else if (initdone && cpu_req) begin
            m_ph <= 1; m_boot <= 1'b0; m_wr <= cpu_we;
            m_addr <= cpu_addr; m_dat <= cpu_wdata;
            m_lanes <= ~cpu_be;
            if (cpu_be == 2'b00) m_err <= 1'b1;
         end
      end else begin
         if (m_ph == W + 1 && !m_wr) m_rdata <= dout;
         m_ph <= (m_ph == W + 2) ? 0 : m_ph + 1;
      end
   end

   function automatic bit in_acc();
      return m_ph >= 2 && m_ph <= W + 1;
   endfunction

   bit run_mon = 1'b0;

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (run_mon) begin
         check("ctrl", {cs, oe, we, adv, lb_ub},
               {m_ph == 0, !(in_acc() && !m_wr), !(in_acc() && m_wr),
                1'b0, (m_ph == 0) ? 2'b11 : m_lanes});
         check("ack", {boot_ack, cpu_ack},
               {m_ph == W + 2 && m_boot, m_ph == W + 2 && !m_boot});
         check("err", error, m_err);
         check("rdata", cpu_rdata, m_rdata);
         if (m_ph != 0 && rst_n) check("addr", sram_address, m_addr);
         if (in_acc() && m_wr) check("wdata", sram_datain, m_dat);
      end
   end

   bit         fix_dout = 1'b0;
   int         last_wlow, last_olow, last_idle, last_lat;
   logic [1:0] last_lanes;

   // Issue one request and wait (bounded) for its ack
   task automatic xact(input bit boot, input bit wr,
                       input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit hold,
                       input bit scramble, input int exp_lat,
                       input string tag);
      int n = 0;
      bit got = 1'b0;
      last_wlow = 0; last_olow = 0; last_idle = 0;
      last_lanes = 2'b11;
      if (boot) begin
         boot_req = 1'b1; boot_addr = a; boot_wdata = d;
      end else begin
         cpu_req = 1'b1; cpu_we = wr; cpu_addr = a;
         cpu_wdata = d; cpu_be = be;
      end
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (!we) last_wlow++;
         if (!oe) last_olow++;
         if (cs) last_idle++;
         else last_lanes = lb_ub;
         if (!fix_dout) dout = 16'($urandom);
         got = boot ? boot_ack : cpu_ack;
         if (!got && scramble && m_ph != 0) begin
            boot_addr = AW'($urandom); boot_wdata = 16'($urandom);
            cpu_addr = AW'($urandom); cpu_wdata = 16'($urandom);
            cpu_be = 2'($urandom); cpu_we = 1'($urandom);
         end
      end
      last_lat = n;
      check({tag, " ack seen"}, got, 1'b1);
      if (exp_lat > 0) check({tag, " latency"}, n, exp_lat);
      if (!hold) begin
         boot_req = 1'b0; cpu_req = 1'b0;
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 run_mon = 1'b1;
      @(negedge clk);
      check("rst ctrl", {cs, oe, we, adv, lb_ub}, 6'b111011);
      check("rst data", {sram_address, sram_datain}, '0);
      check("rst misc", {cpu_rdata, boot_ack, cpu_ack, error}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Bootstrap write before init is done
      xact(1, 1, 22'h000010, 16'hA5A5, 2'b11, 0, 0, W + 2, "boot");
      check("boot we low", last_wlow, W);
      check("boot lanes", last_lanes, 2'b00);
      @(negedge clk);

      // CPU read at top of memory
      initdone = 1'b1;
      fix_dout = 1'b1;
      dout = 16'h1234;
      xact(0, 0, 22'h3FFFFF, 16'h0, 2'b11, 0, 0, W + 2, "rd");
      check("rd oe low", last_olow, W);
      check("rd data", cpu_rdata, 16'h1234);
      fix_dout = 1'b0;
      @(negedge clk);

      // CPU request pends until init is done
      initdone = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 22'h000123; cpu_wdata = 16'h5A5A; cpu_be = 2'b11;
      repeat (10) begin
         @(negedge clk);
         check("pend cs", cs, 1'b1);
         check("pend ack", cpu_ack, 1'b0);
      end
      initdone = 1'b1;
      xact(0, 1, 22'h000123, 16'h5A5A, 2'b11, 0, 0, W + 2, "pend");
      @(negedge clk);

      // Byte-lane write then back-to-back read
      xact(0, 1, 22'h000200, 16'hBEEF, 2'b10, 1, 0, W + 2, "be10");
      check("be10 lanes", last_lanes, 2'b01);
      xact(0, 0, 22'h000200, 16'h0, 2'b11, 0, 0, W + 3, "b2b");
      check("b2b idle gap", last_idle, 1);
      @(negedge clk);

      // Bootstrap request after init is a protocol error
      boot_req = 1'b1; boot_addr = 22'h000040;
      repeat (6) @(negedge clk);
      check("bad boot err", error, 1'b1);
      check("bad boot cs", cs, 1'b1);
      boot_req = 1'b0;
      repeat (3) @(negedge clk);
      check("err sticky", error, 1'b1);

      // Reset in the middle of an access aborts it
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 22'h000055; cpu_wdata = 16'h1111; cpu_be = 2'b11;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort cs we", {cs, we}, 2'b11);
      check("abort ack", cpu_ack, 1'b0);
      check("abort err", error, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xact(0, 1, 22'h000055, 16'h1111, 2'b11, 0, 0, W + 2, "retry");
      @(negedge clk);

      // Empty byte enable flags an error but still completes
      xact(0, 1, 22'h000077, 16'h2222, 2'b00, 0, 0, W + 2, "be00");
      check("be00 err", error, 1'b1);
      @(negedge clk);

      // Randomized traffic with scrambled inputs mid-transaction
      for (int i = 0; i < 120; i++) begin
         int burst;
         if ($urandom_range(0, 2) == 0) begin
            initdone = 1'b0;
            xact(1, 1, AW'($urandom), 16'($urandom), 2'b11, 0, 1,
                 (m_ph == 0) ? W + 2 : W + 3, "r boot");
         end else begin
            initdone = 1'b1;
            burst = $urandom_range(1, 3);
            for (int k = 0; k < burst; k++) begin
               xact(0, 1'($urandom), AW'($urandom), 16'($urandom),
                    2'($urandom), k < burst - 1, 1,
                    (m_ph == 0) ? W + 2 : W + 3, "r cpu");
            end
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      run_mon = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
